// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default filter lengths for the switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_e;

    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one switch line -- synchroniser, bounce filter FSM and registered edge pulses.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   rise_q, rise_d, fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync    = sync_q[SYNC_STAGES-1];
    // cnt holds samples already seen; the current disagreeing sample completes the count
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOW: begin
                if (sync) begin
                    state_d = S_RISE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_RISE_WAIT: begin
                if (!sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            S_HIGH: begin
                if (!sync) begin
                    state_d = S_FALL_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_FALL_WAIT: begin
                if (sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rise_d   = (state_q == S_RISE_WAIT) && (state_d == S_HIGH);
        fall_d   = (state_q == S_FALL_WAIT) && (state_d == S_LOW);
        stable_o = (state_q == S_HIGH) || (state_q == S_FALL_WAIT);
        rise_o   = rise_q;
        fall_o   = fall_q;
    end

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: WIDTH independent debounced switch lines with rise/fall pulses and a change flag.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             any_change
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i   (clock_in),
            .rst_ni  (reset),
            .raw_i   (switch_raw[i]),
            .stable_o(switch_stable[i]),
            .rise_o  (switch_rise[i]),
            .fall_o  (switch_fall[i])
        );
    end

    assign any_change = |{switch_rise, switch_fall};

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed checks of switch_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] raw = 4'b0000;
    logic [3:0] stable, rise, fall;
    logic       any;
    int         n_chk = 0;
    int         n_pass = 0;
    int         rise_cnt [4] = '{0, 0, 0, 0};
    int         fall_cnt [4] = '{0, 0, 0, 0};

    switch_debouncer #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock_in     (clk),
        .reset        (rst_n),
        .switch_raw   (raw),
        .switch_stable(stable),
        .switch_rise  (rise),
        .switch_fall  (fall),
        .any_change   (any)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] += int'(rise[i]);
            fall_cnt[i] += int'(fall[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset then idle
        #1 rst_n = 1'b0;
        #1 check("reset_out", {stable, rise, fall, any}, 13'h0);
        tick(2);
        check("reset_hold", {stable, rise, fall, any}, 13'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("idle", {stable, rise, fall, any}, 13'h0);
        end
        // clean press on line 0: stable after edge k+5
        raw = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("press_wait", {stable, rise, any}, 9'h0);
        end
        tick(1);
        check("press_stable", stable, 4'b0001);
        check("press_rise", rise, 4'b0001);
        check("press_any", any, 1'b1);
        tick(1);
        check("press_rise_end", {rise, any}, 5'h0);
        check("press_hold", stable, 4'b0001);
        // bounce on line 1 never reaches the outputs
        for (int c = 0; c < 20; c++) begin
            raw[1] = (c < 8) && (c % 4 < 2);
            tick(1);
            check("bounce", {stable, rise, fall, any}, {4'b0001, 9'h0});
        end
        // line 2 high, then lines 0 and 2 release together
        raw = 4'b0101;
        tick(8);
        check("two_high", stable, 4'b0101);
        raw = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("release_wait", {stable, fall, any}, {4'b0101, 5'h0});
        end
        tick(1);
        check("release_stable", stable, 4'b0000);
        check("release_fall", fall, 4'b0101);
        check("release_any", any, 1'b1);
        tick(1);
        check("release_end", {stable, rise, fall, any}, 13'h0);
        // reset in the middle of a count on line 3
        raw = 4'b1000;
        tick(3);
        rst_n = 1'b0;
        #1 check("midrst_out", {stable, rise, fall, any}, 13'h0);
        tick(2);
        check("midrst_hold", {stable, rise, fall, any}, 13'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("midrst_wait", {stable, rise, fall, any}, 13'h0);
        end
        tick(1);
        check("midrst_stable", stable, 4'b1000);
        check("midrst_rise", {rise, any}, {4'b1000, 1'b1});
        // long hold on all lines
        raw = 4'b1111;
        tick(8);
        check("all_high", stable, 4'b1111);
        for (int c = 0; c < 200; c++) begin
            tick(1);
            check("hold", {stable, rise, fall, any}, {4'b1111, 9'h0});
            check("hold_cnt0", 32'(dut.g_bit[0].u_bit.cnt_q), 32'd0);
            check("hold_cnt3", 32'(dut.g_bit[3].u_bit.cnt_q), 32'd0);
        end
        check("rises0", rise_cnt[0], 2);
        check("rises1", rise_cnt[1], 1);
        check("rises2", rise_cnt[2], 2);
        check("rises3", rise_cnt[3], 1);
        check("falls0", fall_cnt[0], 1);
        check("falls1", fall_cnt[1], 0);
        check("falls2", fall_cnt[2], 1);
        check("falls3", fall_cnt[3], 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
